// File: rtl/mcs4_ram_bank.sv
// MCS-4 style RAM bank: main/status character storage, per-chip output port, latched SRC address.
// Latency: reads return 1 cycle after the command; backpressure: none, one command per cycle accepted.
module mcs4_ram_bank #(
    parameter int NUM_CHIPS  = 4,
    parameter int NUM_REGS   = 4,
    parameter int NUM_CHARS  = 16,
    parameter int NUM_STATUS = 4,
    parameter int DATA_W     = 4,
    parameter int AUTO_INC   = 0,
    localparam int CW = $clog2(NUM_CHIPS),
    localparam int RW = $clog2(NUM_REGS),
    localparam int XW = $clog2(NUM_CHARS),
    localparam int AW = CW + RW + XW
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        src_valid,
    input  logic [AW-1:0]               src_addr,
    input  logic                        cmd_valid,
    input  logic [3:0]                  cmd_opa,
    input  logic [DATA_W-1:0]           cmd_data,
    output logic                        rd_valid,
    output logic [DATA_W-1:0]           rd_data,
    output logic [NUM_CHIPS*DATA_W-1:0] port_out,
    output logic [AW-1:0]               addr_q
);

    localparam logic [3:0] OP_WRM = 4'd0;
    localparam logic [3:0] OP_WMP = 4'd1;
    localparam logic [3:0] OP_SBM = 4'd8;
    localparam logic [3:0] OP_RDM = 4'd9;
    localparam logic [3:0] OP_ADM = 4'd11;
    localparam int CRW = CW + RW;

    // Status storage is addressed as {chip, reg, n}; slots with n >= NUM_STATUS are never touched.
    logic [DATA_W-1:0] main_mem [2**AW];
    logic [DATA_W-1:0] stat_mem [2**(CRW+2)];
    logic [NUM_CHIPS*DATA_W-1:0] port_q;

    logic [CW-1:0]     chip_sel;
    logic [CRW-1:0]    cr_sel;
    logic [XW-1:0]     char_sel;
    logic [1:0]        stat_n;
    logic              stat_ok;
    logic              is_wrm;
    logic              is_wmp;
    logic              is_wrs;
    logic              is_main_rd;
    logic              is_stat_rd;
    logic              do_inc;
    logic [DATA_W-1:0] rd_next;

    assign chip_sel   = addr_q[AW-1 -: CW];
    assign cr_sel     = addr_q[AW-1 -: CRW];
    assign char_sel   = addr_q[XW-1:0];
    assign stat_n     = cmd_opa[1:0];
    assign stat_ok    = int'(stat_n) < NUM_STATUS;
    assign is_wrm     = cmd_valid && (cmd_opa == OP_WRM);
    assign is_wmp     = cmd_valid && (cmd_opa == OP_WMP);
    assign is_wrs     = cmd_valid && (cmd_opa[3:2] == 2'b01);
    assign is_main_rd = cmd_valid && ((cmd_opa == OP_SBM) || (cmd_opa == OP_RDM) || (cmd_opa == OP_ADM));
    assign is_stat_rd = cmd_valid && (cmd_opa[3:2] == 2'b11);
    assign do_inc     = (AUTO_INC != 0) && (is_wrm || is_main_rd);

    assign rd_next = is_stat_rd ? (stat_ok ? stat_mem[{cr_sel, stat_n}] : '0)
                                : main_mem[addr_q];

    // Storage is not reset, but a command issued while rst is high must not land.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (is_wrm) begin
                main_mem[addr_q] <= cmd_data;
            end
            if (is_wrs && stat_ok) begin
                stat_mem[{cr_sel, stat_n}] <= cmd_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            port_q   <= '0;
        end else begin
            rd_valid <= is_main_rd || is_stat_rd;
            if (is_main_rd || is_stat_rd) begin
                rd_data <= rd_next;
            end
            if (is_wmp) begin
                for (int c = 0; c < NUM_CHIPS; c++) begin
                    if (int'(chip_sel) == c) begin
                        port_q[c*DATA_W +: DATA_W] <= cmd_data;
                    end
                end
            end
            // A fresh SRC wins over the post-access increment; chip/reg bits never carry.
            if (src_valid) begin
                addr_q <= src_addr;
            end else if (do_inc) begin
                addr_q[XW-1:0] <= char_sel + 1'b1;
            end
        end
    end

    assign port_out = port_q;

endmodule

// File: tb/tb_mcs4_ram_bank.sv
// Bench for mcs4_ram_bank: directed vector table, hand sequences and random traffic against a reference model.
// Two instances share stimulus: dut0 uses defaults, dut1 has NUM_STATUS=2 and AUTO_INC=1.
module tb_mcs4_ram_bank;

    logic       clk;
    logic       rst;
    logic       src_valid;
    logic [7:0] src_addr;
    logic       cmd_valid;
    logic [3:0] cmd_opa;
    logic [3:0] cmd_data;

    logic        rd_valid_w [2];
    logic [3:0]  rd_data_w  [2];
    logic [15:0] port_w     [2];
    logic [7:0]  addr_w     [2];

    int n_checks;
    int n_err;

    mcs4_ram_bank u_dut0 (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_addr(src_addr),
        .cmd_valid(cmd_valid), .cmd_opa(cmd_opa), .cmd_data(cmd_data),
        .rd_valid(rd_valid_w[0]), .rd_data(rd_data_w[0]),
        .port_out(port_w[0]), .addr_q(addr_w[0])
    );

    mcs4_ram_bank #(.NUM_STATUS(2), .AUTO_INC(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_addr(src_addr),
        .cmd_valid(cmd_valid), .cmd_opa(cmd_opa), .cmd_data(cmd_data),
        .rd_valid(rd_valid_w[1]), .rd_data(rd_data_w[1]),
        .port_out(port_w[1]), .addr_q(addr_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: memory viewed as [chip][reg][char], address split arithmetically.
    int  m_ns   [2];
    bit  m_ai   [2];
    int  m_main [2][4][4][16];
    bit  m_mk   [2][4][4][16];
    int  m_stat [2][4][4][4];
    bit  m_sk   [2][4][4][4];
    int  m_port [2][4];
    int  m_addr [2];
    bit  m_vld  [2];
    int  m_dat  [2];
    bit  m_dk   [2];

    task automatic model_reset(input int k);
        m_addr[k] = 0;
        m_vld[k]  = 1'b0;
        m_dat[k]  = 0;
        m_dk[k]   = 1'b1;
        for (int c = 0; c < 4; c++) m_port[k][c] = 0;
    endtask

    task automatic model_step(input int k, input bit r, input bit sv, input int sa,
                              input bit cv, input int op, input int d);
        int chip, rg, ch, n;
        bit inc;
        if (r) begin
            model_reset(k);
            return;
        end
        chip = m_addr[k] / 64;
        rg   = (m_addr[k] / 16) % 4;
        ch   = m_addr[k] % 16;
        inc  = 1'b0;
        m_vld[k] = 1'b0;
        if (cv) begin
            if (op == 0) begin
                m_main[k][chip][rg][ch] = d;
                m_mk[k][chip][rg][ch]   = 1'b1;
                inc = m_ai[k];
            end else if (op == 1) begin
                m_port[k][chip] = d;
            end else if (op >= 4 && op <= 7) begin
                n = op - 4;
                if (n < m_ns[k]) begin
                    m_stat[k][chip][rg][n] = d;
                    m_sk[k][chip][rg][n]   = 1'b1;
                end
            end else if (op == 8 || op == 9 || op == 11) begin
                m_vld[k] = 1'b1;
                m_dat[k] = m_main[k][chip][rg][ch];
                m_dk[k]  = m_mk[k][chip][rg][ch];
                inc = m_ai[k];
            end else if (op >= 12) begin
                n = op - 12;
                m_vld[k] = 1'b1;
                if (n < m_ns[k]) begin
                    m_dat[k] = m_stat[k][chip][rg][n];
                    m_dk[k]  = m_sk[k][chip][rg][n];
                end else begin
                    m_dat[k] = 0;
                    m_dk[k]  = 1'b1;
                end
            end
        end
        if (sv) m_addr[k] = sa;
        else if (inc) m_addr[k] = chip * 64 + rg * 16 + (ch + 1) % 16;
    endtask

    function automatic logic [15:0] model_port(input int k);
        logic [15:0] p;
        p = '0;
        for (int c = 0; c < 4; c++) p[c*4 +: 4] = 4'(m_port[k][c]);
        return p;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h", name, k, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit sv, input logic [7:0] sa,
                        input bit cv, input logic [3:0] op, input logic [3:0] d);
        rst       = r;
        src_valid = sv;
        src_addr  = sa;
        cmd_valid = cv;
        cmd_opa   = op;
        cmd_data  = d;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k, r, sv, int'(sa), cv, int'(op), int'(d));
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("model_rd_valid", k, 32'(rd_valid_w[k]), 32'(m_vld[k]));
            if (m_dk[k]) chk("model_rd_data", k, 32'(rd_data_w[k]), 32'(m_dat[k]));
            chk("model_addr_q", k, 32'(addr_w[k]), 32'(m_addr[k]));
            chk("model_port_out", k, 32'(port_w[k]), 32'(model_port(k)));
        end
    endtask

    typedef struct {
        bit         sv;
        logic [7:0] sa;
        bit         cv;
        logic [3:0] op;
        logic [3:0] d;
        bit         ev;
        logic [3:0] ed;
        logic [7:0] ea;
        logic [15:0] ep;
    } vec_t;

    vec_t tbl [20];

    initial begin
        n_checks = 0;
        n_err    = 0;
        m_ns[0] = 4; m_ai[0] = 1'b0;
        m_ns[1] = 2; m_ai[1] = 1'b1;
        model_reset(0);
        model_reset(1);

        // Expected outputs of dut0 after each vector's clock edge.
        tbl[0]  = '{1'b1, 8'h5A, 1'b0, 4'd0,  4'h0, 1'b0, 4'h0, 8'h5A, 16'h0000};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 4'd0,  4'h7, 1'b0, 4'h0, 8'h5A, 16'h0000};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 4'd9,  4'h0, 1'b1, 4'h7, 8'h5A, 16'h0000};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 4'd0,  4'h0, 1'b0, 4'h7, 8'h5A, 16'h0000};
        tbl[4]  = '{1'b1, 8'hC0, 1'b0, 4'd0,  4'h0, 1'b0, 4'h7, 8'hC0, 16'h0000};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 4'd1,  4'h9, 1'b0, 4'h7, 8'hC0, 16'h9000};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 4'd6,  4'hB, 1'b0, 4'h7, 8'hC0, 16'h9000};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 4'd14, 4'h0, 1'b1, 4'hB, 8'hC0, 16'h9000};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 4'd2,  4'h5, 1'b0, 4'hB, 8'hC0, 16'h9000};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 4'd10, 4'h5, 1'b0, 4'hB, 8'hC0, 16'h9000};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 4'd3,  4'h5, 1'b0, 4'hB, 8'hC0, 16'h9000};
        tbl[11] = '{1'b1, 8'h10, 1'b0, 4'd0,  4'h0, 1'b0, 4'hB, 8'h10, 16'h9000};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 4'd0,  4'h6, 1'b0, 4'hB, 8'h10, 16'h9000};
        tbl[13] = '{1'b1, 8'h20, 1'b1, 4'd9,  4'h0, 1'b1, 4'h6, 8'h20, 16'h9000};
        tbl[14] = '{1'b0, 8'h00, 1'b1, 4'd0,  4'h3, 1'b0, 4'h6, 8'h20, 16'h9000};
        tbl[15] = '{1'b0, 8'h00, 1'b1, 4'd8,  4'h0, 1'b1, 4'h3, 8'h20, 16'h9000};
        tbl[16] = '{1'b0, 8'h00, 1'b1, 4'd11, 4'h0, 1'b1, 4'h3, 8'h20, 16'h9000};
        tbl[17] = '{1'b0, 8'h00, 1'b1, 4'd0,  4'hE, 1'b0, 4'h3, 8'h20, 16'h9000};
        tbl[18] = '{1'b0, 8'h00, 1'b1, 4'd9,  4'h0, 1'b1, 4'hE, 8'h20, 16'h9000};
        tbl[19] = '{1'b0, 8'h00, 1'b1, 4'd1,  4'h5, 1'b0, 4'hE, 8'h20, 16'h9005};

        rst = 1'b1; src_valid = 1'b0; src_addr = '0;
        cmd_valid = 1'b0; cmd_opa = '0; cmd_data = '0;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_addr_q", k, 32'(addr_w[k]), 32'h0);
            chk("reset_rd_valid", k, 32'(rd_valid_w[k]), 32'h0);
            chk("reset_rd_data", k, 32'(rd_data_w[k]), 32'h0);
            chk("reset_port_out", k, 32'(port_w[k]), 32'h0);
        end
        step(1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 4'h0);

        for (int i = 0; i < 20; i++) begin
            step(1'b0, tbl[i].sv, tbl[i].sa, tbl[i].cv, tbl[i].op, tbl[i].d);
            chk($sformatf("vec%0d_rd_valid", i), 0, 32'(rd_valid_w[0]), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_rd_data", i), 0, 32'(rd_data_w[0]), 32'(tbl[i].ed));
            chk($sformatf("vec%0d_addr_q", i), 0, 32'(addr_w[0]), 32'(tbl[i].ea));
            chk($sformatf("vec%0d_port_out", i), 0, 32'(port_w[0]), 32'(tbl[i].ep));
        end

        // Auto-increment wrap on dut1: chars 14,15,0,1 of chip0 reg0.
        step(1'b0, 1'b1, 8'h0E, 1'b0, 4'd0, 4'h0);
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 4'(i));
        chk("autoinc_addr_after_wrm", 1, 32'(addr_w[1]), 32'h02);
        step(1'b0, 1'b1, 8'h0E, 1'b0, 4'd0, 4'h0);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1, 4'd9, 4'h0);
            chk($sformatf("autoinc_rdm%0d_valid", i), 1, 32'(rd_valid_w[1]), 32'h1);
            chk($sformatf("autoinc_rdm%0d_data", i), 1, 32'(rd_data_w[1]), 32'(i));
        end
        chk("autoinc_addr_after_rdm", 1, 32'(addr_w[1]), 32'h02);

        // Status characters beyond NUM_STATUS on dut1 are absent.
        step(1'b0, 1'b1, 8'h00, 1'b0, 4'd0, 4'h0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 4'd7, 4'hF);
        step(1'b0, 1'b0, 8'h00, 1'b1, 4'd15, 4'h0);
        chk("rd3_absent_valid", 1, 32'(rd_valid_w[1]), 32'h1);
        chk("rd3_absent_data", 1, 32'(rd_data_w[1]), 32'h0);
        chk("rd3_present_data", 0, 32'(rd_data_w[0]), 32'hF);
        step(1'b0, 1'b0, 8'h00, 1'b1, 4'd5, 4'h3);
        step(1'b0, 1'b0, 8'h00, 1'b1, 4'd13, 4'h0);
        chk("rd1_data", 1, 32'(rd_data_w[1]), 32'h3);
        chk("rd1_data", 0, 32'(rd_data_w[0]), 32'h3);

        // Reset mid-stream: async clear, and a command under reset leaves no trace.
        step(1'b0, 1'b1, 8'hC0, 1'b0, 4'd0, 4'h0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 4'd1, 4'hA);
        chk("wmp_port_before_rst", 0, 32'(port_w[0]), 32'hA005);
        step(1'b0, 1'b0, 8'h00, 1'b1, 4'd9, 4'h0);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("async_rst_port_out", k, 32'(port_w[k]), 32'h0);
            chk("async_rst_rd_valid", k, 32'(rd_valid_w[k]), 32'h0);
        end
        step(1'b1, 1'b0, 8'h00, 1'b1, 4'd9, 4'h0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 4'h0);
        for (int k = 0; k < 2; k++) begin
            chk("post_rst_rd_valid", k, 32'(rd_valid_w[k]), 32'h0);
            chk("post_rst_addr_q", k, 32'(addr_w[k]), 32'h0);
        end

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) == 0),
                 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 9) < 7),
                 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mcs4_ram_bank.md
MCS4_RAM_BANK -- requirements
Module: mcs4_ram_bank

Interface
REQ-001 Parameter NUM_CHIPS, default 4, number of RAM chips in the bank; power of two, 2..8.
REQ-002 Parameter NUM_REGS, default 4, registers per chip; power of two, 2..8.
REQ-003 Parameter NUM_CHARS, default 16, main-memory characters per register; power of two, 4..32.
REQ-004 Parameter NUM_STATUS, default 4, status characters per register; range 1..4.
REQ-005 Parameter DATA_W, default 4, character width in bits.
REQ-006 Parameter AUTO_INC, default 0; 1 enables post-access main-character index increment.
REQ-007 Derived widths: CW=clog2(NUM_CHIPS), RW=clog2(NUM_REGS), XW=clog2(NUM_CHARS), AW=CW+RW+XW.
REQ-008 clk  input  1  single clock; all state updates on the rising edge.
REQ-009 rst  input  1  asynchronous, active-high reset.
REQ-010 src_valid  input  1  latch a new address (SRC) this cycle.
REQ-011 src_addr  input  AW  {chip, reg, char}, chip in MSBs.
REQ-012 cmd_valid  input  1  execute cmd_opa this cycle.
REQ-013 cmd_opa  input  4  I/O-RAM operation code: WRM=0, WMP=1, WR0..WR3=4..7, SBM=8, RDM=9, ADM=11, RD0..RD3=12..15.
REQ-014 cmd_data  input  DATA_W  write data (accumulator value).
REQ-015 rd_valid  output  1  read response strobe.
REQ-016 rd_data  output  DATA_W  read response data.
REQ-017 port_out  output  NUM_CHIPS*DATA_W  per-chip output port, chip 0 in LSBs.
REQ-018 addr_q  output  AW  currently latched address, for debug.

Function
REQ-019 Storage: main array NUM_CHIPS x NUM_REGS x NUM_CHARS x DATA_W; status array NUM_CHIPS x NUM_REGS x NUM_STATUS x DATA_W; port register per chip.
REQ-020 src_valid=1 loads addr_q from src_addr at the clock edge.
REQ-021 WRM: main[chip][reg][char] <= cmd_data at the edge.
REQ-022 WMP: port register of addressed chip <= cmd_data; other ports unchanged.
REQ-023 WRn: status[chip][reg][n] <= cmd_data if n < NUM_STATUS, else no write.
REQ-024 RDM, SBM, ADM: rd_valid=1 and rd_data=main[chip][reg][char] in the cycle after cmd_valid (1-cycle latency, registered).
REQ-025 RDn: rd_valid=1 next cycle, rd_data=status[chip][reg][n], or 0 if n >= NUM_STATUS.
REQ-026 Opcodes 2 (WRR), 3, 10 (RDR): no state change, no rd_valid; bank ignores them.
REQ-027 rd_valid is high for exactly one cycle per read command; rd_data holds its last value while rd_valid=0.
REQ-028 Back-to-back commands on consecutive cycles are accepted at full rate, no stall.
REQ-029 AUTO_INC=1: after WRM, RDM, SBM or ADM, the char field of addr_q increments by 1 modulo NUM_CHARS; chip and reg fields never change.
REQ-030 AUTO_INC=0, or any other opcode: addr_q changes only on src_valid.
REQ-031 Simultaneous src_valid and cmd_valid: the command uses the old addr_q; afterwards addr_q = src_addr, and src_addr takes priority over auto-increment.
REQ-032 Read and write to the same location in consecutive cycles: the read returns the newly written value.
REQ-033 Char wrap: with AUTO_INC=1 and char=NUM_CHARS-1, the next access index is 0 in the same register.

Reset
REQ-034 rst=1 asynchronously clears addr_q, rd_valid, rd_data and all port registers to 0.
REQ-035 Main and status arrays are not reset; contents are undefined until written.
REQ-036 A command with cmd_valid=1 in a cycle where rst is asserted has no effect, and no rd_valid follows after rst deasserts.

Verification
REQ-037 Default params: SRC 0x5A (chip1, reg1, char10), WRM data 0x7, then RDM -> next cycle rd_valid=1, rd_data=0x7.
REQ-038 SRC 0xC0, WMP 0x9 -> port_out[15:12]=0x9; other nibbles remain 0.
REQ-039 NUM_STATUS=2: WR3 data 0xF then RD3 -> rd_data=0; WR1 data 0x3 then RD1 -> rd_data=0x3.
REQ-040 AUTO_INC=1: SRC 0x0E, then four WRM ops with data 1,2,3,4 -> chars 14,15,0,1 of chip0 reg0 hold 1,2,3,4 and addr_q=0x02.
REQ-041 Same cycle: src_valid with 0x20, plus RDM at old addr 0x10 (holding 0x6) -> rd_data=0x6 and addr_q=0x20.
REQ-042 WMP 0xA, then rst pulse mid-stream with RDM pending -> port_out=0, and no rd_valid after release.
